// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbiter for the common data bus (CDB).
// N_REQ result producers compete for one {tag,data} broadcast per cycle.
// The search starts at rr_ptr_q and the pointer moves just past each winner,
// so a held request is granted within N_REQ cycles.
// Optional build macro CDB_ARB_OUTREG_EN adds a registered output stage
// (latency 1). Without it the winner's payload drives the bus in the same cycle.
// The tag width comes from the global ROB_WIDTH macro.

`ifndef ROB_WIDTH
`define ROB_WIDTH 6
`endif

module cdb_arbiter #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 32
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         flush,
    input  logic [N_REQ-1:0]             req_valid,
    input  logic [N_REQ*`ROB_WIDTH-1:0]  req_tag,
    input  logic [N_REQ*DATA_W-1:0]      req_data,
    output logic [N_REQ-1:0]             req_ready,
    output logic                         cdb_valid,
    output logic [`ROB_WIDTH-1:0]        cdb_tag,
    output logic [DATA_W-1:0]            cdb_data
);

    localparam int TAG_W = `ROB_WIDTH;
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } beat_t;

    logic [PTR_W-1:0] rr_ptr_q;
    logic [PTR_W-1:0] rr_ptr_d;
    logic             arb_en;
    logic             grant_any;
    logic [PTR_W-1:0] win_idx;
    logic [N_REQ-1:0] grant;
    beat_t            beat_d;

    // Reset and flush both block arbitration; reset also clears state.
    assign arb_en = reset_n & ~flush;

    // Port index reached by stepping 'off' places from 'base', wrapping at N_REQ.
    function automatic logic [PTR_W-1:0] rot_idx(input logic [PTR_W-1:0] base,
                                                 input int off);
        int s;
        s = (int'(base) + off) % N_REQ;
        return PTR_W'(s);
    endfunction

    // Winner search: the first valid port found scanning forward from rr_ptr_q.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // so no path leaves it unassigned and no latch is inferred.
        grant_any = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            // NOTE: blocking '=' here, so later iterations see the updated
            // grant_any. Clocked blocks below use '<=' only.
            if (!grant_any && arb_en && req_valid[rot_idx(rr_ptr_q, k)]) begin
                grant_any = 1'b1;
                win_idx   = rot_idx(rr_ptr_q, k);
            end
        end
    end

    // One-hot grant decode. The pointer moves past the winner and holds otherwise.
    always_comb begin
        grant    = '0;
        rr_ptr_d = rr_ptr_q;
        if (grant_any) begin
            grant[win_idx] = 1'b1;
            rr_ptr_d = (win_idx == PTR_W'(N_REQ - 1)) ? '0 : win_idx + PTR_W'(1);
        end
    end

    assign req_ready = grant;

    // Winner payload. It is forced to zero when there is no grant, so the bus never carries stale data.
    always_comb begin
        beat_d = '0;
        if (grant_any) begin
            beat_d.valid = 1'b1;
            beat_d.tag   = req_tag[int'(win_idx)*TAG_W +: TAG_W];
            beat_d.data  = req_data[int'(win_idx)*DATA_W +: DATA_W];
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous. It is sampled only on the clock edge.
        if (!reset_n) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

`ifdef CDB_ARB_OUTREG_EN
    beat_t out_q;

    // Registered output stage. It captures this cycle's winner for the next cycle's beat.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_q <= '0;
        end else begin
            out_q <= beat_d;
        end
    end

    // Flush also kills the beat already captured, so that beat never reaches the consumers.
    always_comb begin
        cdb_valid = out_q.valid & arb_en;
        cdb_tag   = cdb_valid ? out_q.tag  : '0;
        cdb_data  = cdb_valid ? out_q.data : '0;
    end
`else
    // Same-cycle broadcast of the winner's payload.
    always_comb begin
        cdb_valid = beat_d.valid;
        cdb_tag   = beat_d.tag;
        cdb_data  = beat_d.data;
    end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: directed scenarios followed by random traffic.
// A reference model queues the expected grant and broadcast for each driven cycle.
// A monitor on the falling edge pops those entries and compares them with the DUT outputs.

`ifndef ROB_WIDTH
`define ROB_WIDTH 6
`endif

module tb_cdb_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int TW = `ROB_WIDTH;
`ifdef CDB_ARB_OUTREG_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    logic              clk;
    logic              reset_n;
    logic              flush;
    logic [N-1:0]      req_valid;
    logic [N*TW-1:0]   req_tag;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      req_ready;
    logic              cdb_valid;
    logic [TW-1:0]     cdb_tag;
    logic [DW-1:0]     cdb_data;

    cdb_arbiter #(.N_REQ(N), .DATA_W(DW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .req_valid (req_valid),
        .req_tag   (req_tag),
        .req_data  (req_data),
        .req_ready (req_ready),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_data  (cdb_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int            due;
        logic [TW-1:0] tag;
        logic [DW-1:0] data;
    } exp_beat_t;

    // Requester state and the reference pointer.
    bit            pend [N];
    logic [TW-1:0] m_tag [N];
    logic [DW-1:0] m_data [N];
    int            m_ptr;
    int            cyc;
    int            tag_ctr;

    exp_beat_t     beat_q [$];
    logic [N-1:0]  grant_q [$];

    int total;
    int bad;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic raise(input int i);
        if (!pend[i]) begin
            pend[i]   = 1'b1;
            m_tag[i]  = TW'(tag_ctr);
            m_data[i] = $urandom;
            tag_ctr++;
        end
    endtask

    task automatic raise_with(input int i, input logic [TW-1:0] t, input logic [DW-1:0] d);
        pend[i]   = 1'b1;
        m_tag[i]  = t;
        m_data[i] = d;
    endtask

    task automatic raise_mask(input logic [N-1:0] m);
        for (int i = 0; i < N; i++) if (m[i]) raise(i);
    endtask

    // Winner = pending port at the smallest forward distance from the pointer.
    function automatic int pick(input int ptr);
        int best  = -1;
        int bestd = N;
        for (int i = 0; i < N; i++) begin
            if (pend[i] && ((i - ptr + N) % N) < bestd) begin
                bestd = (i - ptr + N) % N;
                best  = i;
            end
        end
        return best;
    endfunction

    // Drive one cycle, queue the expected response, then advance the model past the edge.
    task automatic step(input logic rst, input logic fl);
        logic [N-1:0] eg;
        int           w;
        exp_beat_t    b;
        reset_n = rst;
        flush   = fl;
        for (int i = 0; i < N; i++) begin
            req_valid[i] = pend[i];
            req_tag[i*TW +: TW] = pend[i] ? m_tag[i]  : TW'($urandom);
            req_data[i*DW +: DW] = pend[i] ? m_data[i] : DW'($urandom);
        end
        // A beat due in a reset or flush cycle never appears on the bus.
        while (beat_q.size() > 0 && beat_q[0].due == cyc && (!rst || fl))
            void'(beat_q.pop_front());
        w  = (rst && !fl) ? pick(m_ptr) : -1;
        eg = '0;
        if (w >= 0) begin
            eg[w]  = 1'b1;
            b.due  = cyc + LAT;
            b.tag  = m_tag[w];
            b.data = m_data[w];
            beat_q.push_back(b);
        end
        grant_q.push_back(eg);
        @(posedge clk);
        #1;
        if (!rst) begin
            m_ptr = 0;
        end else if (w >= 0) begin
            m_ptr   = (w + 1) % N;
            pend[w] = 1'b0;
        end
        cyc++;
    endtask

    // Monitor: compares grant and bus contents mid-cycle against the queued expectations.
    logic [N-1:0] mon_eg;
    exp_beat_t    mon_b;
    logic         mon_v;
    always @(negedge clk) begin
        if (grant_q.size() > 0) begin
            mon_eg = grant_q.pop_front();
            check("req_ready", 64'(req_ready), 64'(mon_eg));
            mon_v = (beat_q.size() > 0 && beat_q[0].due == cyc);
            check("cdb_valid", 64'(cdb_valid), 64'(mon_v));
            if (mon_v) begin
                mon_b = beat_q.pop_front();
                check("cdb_tag", 64'(cdb_tag), 64'(mon_b.tag));
                check("cdb_data", 64'(cdb_data), 64'(mon_b.data));
            end else begin
                check("idle_tag", 64'(cdb_tag), 64'd0);
                check("idle_data", 64'(cdb_data), 64'd0);
            end
        end
    end

    initial begin
        total = 0; bad = 0; cyc = 0; tag_ctr = 0; m_ptr = 0;
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b0; m_tag[i] = '0; m_data[i] = '0;
        end
        reset_n = 1'b0; flush = 1'b0; req_valid = '0; req_tag = '0; req_data = '0;
        @(posedge clk);
        #1;

        // Reset held with every port valid, then release: grants 0,1,2,3.
        raise_mask(4'b1111);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        repeat (4) step(1'b1, 1'b0);

        // All ports held valid: grants 0,1,2,3,0,1.
        repeat (6) begin
            raise_mask(4'b1111);
            step(1'b1, 1'b0);
        end
        repeat (4) step(1'b1, 1'b0);

        // A single requester with a known payload.
        raise_with(2, TW'(5), 32'hDEADBEEF);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);

        // Ports 1 and 3 valid behind a pointer that has just passed port 2.
        raise_with(2, TW'(9), 32'h0000_1234);
        step(1'b1, 1'b0);
        raise_mask(4'b1010);
        repeat (3) step(1'b1, 1'b0);

        // Pointer wrap from 3 to 0.
        raise(3);
        step(1'b1, 1'b0);
        raise(0);
        step(1'b1, 1'b0);

        // Flush right after a grant, then recovery.
        raise_mask(4'b0111);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        repeat (3) step(1'b1, 1'b0);

        // Reset and flush asserted together.
        raise_mask(4'b1100);
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        repeat (3) step(1'b1, 1'b0);

        // Random traffic with occasional flush and reset.
        repeat (400) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 2) == 0) raise(i);
            step(($urandom_range(0, 59) != 0), ($urandom_range(0, 9) == 0));
        end

        // Drain, then confirm every expected beat was observed.
        repeat (N + 2) step(1'b1, 1'b0);
        check("beats_drained", 64'(beat_q.size()), 64'd0);
        check("grants_drained", 64'(grant_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
